// File: rtl/decode_stage.sv
// RISC-V decode stage: splits an instruction into fields, classifies its format and
// builds the sign-extended immediate, behind a registered valid/ready output stage.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [5:0]      shamt,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  dec_t        dec_in, out_q;
  fmt_e        f;
  logic [31:0] imm32;
  logic        out_vld, in_hs;

  always_comb begin
    f = FMT_ILL;
    if (in_insn[1:0] == 2'b11) begin
      case (in_insn[6:0])
        7'b0110011:                                         f = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111:                             f = FMT_I;
        7'b0100011:                                         f = FMT_S;
        7'b1100011:                                         f = FMT_B;
        7'b0110111, 7'b0010111:                             f = FMT_U;
        7'b1101111:                                         f = FMT_J;
        // word-sized ops exist only on RV64
        7'b0011011: f = (XLEN == 64) ? FMT_I : FMT_ILL;
        7'b0111011: f = (XLEN == 64) ? FMT_R : FMT_ILL;
        default:                                            f = FMT_ILL;
      endcase
    end

    imm32 = '0;
    case (f)
      FMT_I:   imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
      FMT_S:   imm32 = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
      FMT_B:   imm32 = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
      FMT_U:   imm32 = {in_insn[31:12], 12'b0};
      FMT_J:   imm32 = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec_in         = '0;
    dec_in.pc      = in_pc;
    dec_in.opcode  = in_insn[6:0];
    dec_in.rd      = in_insn[11:7];
    dec_in.funct3  = in_insn[14:12];
    dec_in.rs1     = in_insn[19:15];
    dec_in.rs2     = in_insn[24:20];
    dec_in.funct7  = in_insn[31:25];
    dec_in.shamt   = (XLEN == 64) ? in_insn[25:20] : {1'b0, in_insn[24:20]};
    dec_in.imm     = XLEN'($signed(imm32));
    dec_in.fmt     = f;
    dec_in.illegal = (f == FMT_ILL);
  end

  assign in_hs = in_valid & in_ready;

  generate
    if (SKID) begin : g_skid
      dec_t skid_q;
      logic skid_vld;

      // in_ready comes straight from a flop: no path from out_ready
      assign in_ready = ~skid_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld  <= 1'b0;
          skid_vld <= 1'b0;
          out_q    <= '0;
          skid_q   <= '0;
        end else if (flush) begin
          out_vld  <= 1'b0;
          skid_vld <= 1'b0;
        end else if (!out_vld || out_ready) begin
          if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
          end else begin
            out_vld <= in_hs;
            if (in_hs) out_q <= dec_in;
          end
        end else if (in_hs) begin
          skid_q   <= dec_in;
          skid_vld <= 1'b1;
        end
      end
    end else begin : g_reg
      assign in_ready = out_ready | ~out_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld <= 1'b0;
          out_q   <= '0;
        end else if (flush) begin
          out_vld <= 1'b0;
        end else if (in_ready) begin
          out_vld <= in_hs;
          if (in_hs) out_q <= dec_in;
        end
      end
    end
  endgenerate

  assign out_valid = out_vld;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign rd        = out_q.rd;
  assign funct3    = out_q.funct3;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct7    = out_q.funct7;
  assign shamt     = out_q.shamt;
  assign imm       = out_q.imm;
  assign fmt       = out_q.fmt;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: u0 is RV32 with skid buffer, u1 is RV64 with a single output register.
module tb_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] insn = '0;
  logic [63:0] pc = '0;
  logic iv0 = 0, or0 = 0, iv1 = 0, or1 = 0;

  logic ir0, ov0, il0, ir1, ov1, il1;
  logic [31:0] pc0o, im0;
  logic [63:0] pc1o, im1;
  logic [6:0] op0, f70, op1, f71;
  logic [4:0] rd0, rs10, rs20, rd1, rs11, rs21;
  logic [2:0] f30, fm0, f31, fm1;
  logic [5:0] sh0, sh1;

  decode_stage #(.XLEN(32), .SKID(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0),
    .in_insn(insn), .in_pc(pc[31:0]), .out_valid(ov0), .out_ready(or0), .out_pc(pc0o),
    .opcode(op0), .rd(rd0), .funct3(f30), .rs1(rs10), .rs2(rs20), .funct7(f70),
    .shamt(sh0), .imm(im0), .fmt(fm0), .illegal(il0));

  decode_stage #(.XLEN(64), .SKID(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(iv1), .in_ready(ir1),
    .in_insn(insn), .in_pc(pc), .out_valid(ov1), .out_ready(or1), .out_pc(pc1o),
    .opcode(op1), .rd(rd1), .funct3(f31), .rs1(rs11), .rs2(rs21), .funct7(f71),
    .shamt(sh1), .imm(im1), .fmt(fm1), .illegal(il1));

  typedef struct packed {
    logic [63:0] pc; logic [6:0] op; logic [4:0] rd; logic [2:0] f3;
    logic [4:0] rs1; logic [4:0] rs2; logic [6:0] f7; logic [5:0] sh;
    logic [63:0] imm; logic [2:0] fmt; logic il;
  } rec_t;

  rec_t q0[$], q1[$];
  rec_t ma0, ma1, me0, me1;
  int pops0[$];
  int cyc = 0;
  int total = 0, passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input logic [63:0] p, input logic [31:0] i, input bit x64,
                              input logic [2:0] f, input logic [63:0] im);
    rec_t r;
    r.pc = p; r.op = i[6:0]; r.rd = i[11:7]; r.f3 = i[14:12];
    r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.f7 = i[31:25];
    r.sh = x64 ? i[25:20] : {1'b0, i[24:20]};
    r.imm = im; r.fmt = f; r.il = (f == 3'd7);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [169:0] a, input logic [169:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  // monitors: a transfer happens at the coming edge when valid && ready
  always begin
    @(negedge clk); #2;
    if (ov0 && or0 && !flush) begin
      ma0 = {64'(pc0o), op0, rd0, f30, rs10, rs20, f70, sh0, 64'(im0), fm0, il0};
      if (q0.size() == 0) begin
        total++; $display("FAIL out0_unexpected: got %h expected nothing", ma0);
      end else begin
        me0 = q0.pop_front(); chk("out0", ma0, me0); pops0.push_back(cyc);
      end
    end
    if (ov1 && or1) begin
      ma1 = {pc1o, op1, rd1, f31, rs11, rs21, f71, sh1, im1, fm1, il1};
      if (q1.size() == 0) begin
        total++; $display("FAIL out1_unexpected: got %h expected nothing", ma1);
      end else begin
        me1 = q1.pop_front(); chk("out1", ma1, me1);
      end
    end
  end

  task automatic send(input int d, input logic [31:0] i, input logic [63:0] p,
                      input logic [2:0] f, input logic [63:0] im, output int waits);
    bit ok;
    @(negedge clk);
    insn = i; pc = p; waits = 0;
    if (d == 0) iv0 = 1'b1; else iv1 = 1'b1;
    while (1) begin
      #1 ok = (d == 0) ? ir0 : ir1;
      @(posedge clk);
      if (ok) begin
        if (!flush) begin
          if (d == 0) q0.push_back(mk(p, i, 1'b0, f, im));
          else        q1.push_back(mk(p, i, 1'b1, f, im));
        end
        break;
      end
      waits++;
      if (waits > 50) begin
        total++; $display("FAIL send_timeout: got no accept expected accept, insn %h", i);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk); iv0 = 1'b0; iv1 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", q0.size() + q1.size(), 0);
  endtask

  logic [31:0] v32 [12] = '{32'hFFF10093, 32'hFE000EE3, 32'h00000000, 32'h0000A0B7,
                            32'hFFDFF06F, 32'h0020A423, 32'hFE112E23, 32'h002081B3,
                            32'hFFF1009B, 32'h00000011, 32'h00000073, 32'h03F09093};
  logic [2:0]  f32 [12] = '{3'd1, 3'd3, 3'd7, 3'd4, 3'd5, 3'd2, 3'd2, 3'd0, 3'd7, 3'd7, 3'd1, 3'd1};
  logic [31:0] m32 [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0000A000, 32'hFFFFFFFC,
                            32'h8, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3F};
  logic [31:0] v64 [5] = '{32'hFFF1009B, 32'h002081BB, 32'h03F09093, 32'h00000000, 32'hFFDFF06F};
  logic [2:0]  f64 [5] = '{3'd1, 3'd0, 3'd1, 3'd7, 3'd5};
  logic [63:0] m64 [5] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h3F, 64'h0, 64'hFFFFFFFFFFFFFFFC};

  initial begin
    int w;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid0", ov0, 0);
    chk("rst_in_ready0", ir0, 1);
    chk("rst_out_pc0", pc0o, 0);
    chk("rst_in_ready1", ir1, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    or0 = 1'b1;

    // decode table on RV32, streamed back to back
    for (int k = 0; k < 12; k++) begin
      send(0, v32[k], 64'h1000 + 64'(4 * k), f32[k], 64'(m32[k]), w);
      if (k == 0) chk("first_hs_wait", w, 0);
    end
    idle();
    drain();

    // backpressure: A, B accepted, C held until release
    or0 = 1'b0; pops0.delete();
    send(0, 32'h00100093, 64'h2000, 3'd1, 64'h1, w);
    send(0, 32'h00200113, 64'h2004, 3'd1, 64'h2, w);
    fork
      send(0, 32'h00300193, 64'h2008, 3'd1, 64'h3, w);
      begin
        @(negedge clk); #1;
        chk("bp_in_ready_low", ir0, 0);
        chk("bp_out_valid", ov0, 1);
        @(negedge clk); @(negedge clk);
        or0 = 1'b1;
      end
    join
    idle();
    drain();
    chk("bp_pop_count", pops0.size(), 3);
    chk("bp_gap_ab", pops0[1] - pops0[0], 1);
    chk("bp_gap_bc", pops0[2] - pops0[1], 1);

    // flush with output full, skid empty, concurrent input handshake
    or0 = 1'b0;
    send(0, 32'h00400213, 64'h3000, 3'd1, 64'h4, w);
    @(negedge clk);
    insn = 32'h00500293; pc = 64'h3004; iv0 = 1'b1; flush = 1'b1;
    #1 chk("fl_hs_ready", ir0, 1);
    @(negedge clk);
    flush = 1'b0; iv0 = 1'b0; q0.delete();
    #1;
    chk("fl1_out_valid", ov0, 0);
    chk("fl1_in_ready", ir0, 1);

    // flush with both entries full
    send(0, 32'h00400213, 64'h3010, 3'd1, 64'h4, w);
    send(0, 32'h00600313, 64'h3014, 3'd1, 64'h6, w);
    @(negedge clk);
    insn = 32'h00500293; pc = 64'h3018; iv0 = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; iv0 = 1'b0; q0.delete();
    #1;
    chk("fl2_out_valid", ov0, 0);
    chk("fl2_in_ready", ir0, 1);
    or0 = 1'b1; pops0.delete();
    send(0, 32'h00700393, 64'h3020, 3'd1, 64'h7, w);
    idle();
    drain();
    chk("fl_only_g", pops0.size(), 1);

    // reset while stalled with both entries full
    or0 = 1'b0;
    send(0, 32'h00800413, 64'h4000, 3'd1, 64'h8, w);
    send(0, 32'h00900493, 64'h4004, 3'd1, 64'h9, w);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", ov0, 0);
    chk("rst_mid_in_ready", ir0, 1);
    chk("rst_mid_imm", im0, 0);
    q0.delete();
    #1 rst_n = 1'b1;
    or0 = 1'b1; pops0.delete();
    send(0, 32'h00A00513, 64'h4010, 3'd1, 64'hA, w);
    idle();
    drain();
    chk("rst_single_out", pops0.size(), 1);
    chk("rst_after_valid", ov0, 0);

    // RV64 without skid: in_ready follows out_ready while full
    or1 = 1'b0;
    send(1, v64[0], 64'h8000_0000_0000_1000, f64[0], m64[0], w);
    idle();
    #1 chk("s0_ready_stalled", ir1, 0);
    or1 = 1'b1;
    #0.5 chk("s0_ready_released", ir1, 1);
    for (int k = 1; k < 5; k++)
      send(1, v64[k], 64'h8000_0000_0000_1000 + 64'(4 * k), f64[k], m64[k], w);
    idle();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
